// File: rtl/issue_ro_split_stage_pkg.sv
// Shared definitions for the IS->RO stage: address/data types, split count and state enum.
package cpu_defs;

    localparam int unsigned REG_AW_DEF    = 5;
    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned MAX_SPLIT_DEF = 3;
    localparam int unsigned SPLIT_W_DEF   = $clog2(MAX_SPLIT_DEF + 1);

    typedef logic [REG_AW_DEF-1:0]  reg_addr_t;
    typedef logic [DATA_W_DEF-1:0]  uint32_t;
    typedef logic [SPLIT_W_DEF-1:0] split_cnt_t;

    typedef enum logic {
        IDLE,
        REPLAY
    } state_t;

endpackage

// File: rtl/issue_ro_split_stage_fwd.sv
// One operand: priority select over FWD_DEPTH x ISSUE_NUM producers, register 0 reads as zero.
module operand_forward_mux #(
    parameter int unsigned ISSUE_NUM = 2,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned FWD_DEPTH = 4
) (
    input  logic [FWD_DEPTH*ISSUE_NUM-1:0]        fwd_we,
    input  logic [FWD_DEPTH*ISSUE_NUM*REG_AW-1:0] fwd_waddr,
    input  logic [FWD_DEPTH*ISSUE_NUM*DATA_W-1:0] fwd_wdata,
    input  logic [REG_AW-1:0]                     raddr,
    input  logic [DATA_W-1:0]                     rdata,
    output logic [DATA_W-1:0]                     data
);

    // Oldest stage / lowest lane first, so later hits override: youngest stage, highest lane wins.
    always_comb begin
        data = rdata;
        for (int s = FWD_DEPTH - 1; s >= 0; s--) begin
            for (int l = 0; l < ISSUE_NUM; l++) begin
                if (fwd_we[s*ISSUE_NUM+l] &&
                    fwd_waddr[(s*ISSUE_NUM+l)*REG_AW +: REG_AW] == raddr) begin
                    data = fwd_wdata[(s*ISSUE_NUM+l)*DATA_W +: DATA_W];
                end
            end
        end
        if (raddr == '0) begin
            data = '0;
        end
    end

endmodule

// File: rtl/issue_ro_split_stage.sv
// IS->RO pipeline register with RF address generation, operand forwarding and
// multi-beat split replay of one lane with incremented register indices.
module issue_ro_split_stage
    import cpu_defs::*;
#(
    parameter int unsigned ISSUE_NUM = 2,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned FWD_DEPTH = 4,
    parameter int unsigned MAX_SPLIT = 3,
    parameter int unsigned SPLIT_W   = $clog2(MAX_SPLIT + 1),
    parameter int unsigned PAYLOAD_W = 64
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  stall_in,
    input  logic                                  flush,
    input  logic [ISSUE_NUM-1:0]                  in_valid,
    input  logic [ISSUE_NUM*PAYLOAD_W-1:0]        in_payload,
    input  logic [ISSUE_NUM*REG_AW-1:0]           in_rs1,
    input  logic [ISSUE_NUM*REG_AW-1:0]           in_rs2,
    input  logic [ISSUE_NUM*REG_AW-1:0]           in_rd,
    input  logic [ISSUE_NUM*SPLIT_W-1:0]          in_split,
    output logic                                  in_ready,
    output logic [2*ISSUE_NUM*REG_AW-1:0]         reg_raddr,
    input  logic [2*ISSUE_NUM*DATA_W-1:0]         reg_rdata,
    input  logic [FWD_DEPTH*ISSUE_NUM-1:0]        fwd_we,
    input  logic [FWD_DEPTH*ISSUE_NUM*REG_AW-1:0] fwd_waddr,
    input  logic [FWD_DEPTH*ISSUE_NUM*DATA_W-1:0] fwd_wdata,
    output logic [ISSUE_NUM-1:0]                  out_valid,
    output logic [ISSUE_NUM*PAYLOAD_W-1:0]        out_payload,
    output logic [ISSUE_NUM*REG_AW-1:0]           out_rd,
    output logic [ISSUE_NUM*SPLIT_W-1:0]          out_beat,
    output logic [ISSUE_NUM*DATA_W-1:0]           out_op1,
    output logic [ISSUE_NUM*DATA_W-1:0]           out_op2
);

    localparam int unsigned LANE_W = (ISSUE_NUM > 1) ? $clog2(ISSUE_NUM) : 1;

    state_t                         state_q, state_d;
    logic [SPLIT_W-1:0]             rem_q, rem_d;
    logic [SPLIT_W-1:0]             beat_q, beat_d;
    logic [LANE_W-1:0]              lane_q, lane_d;
    logic [ISSUE_NUM-1:0]           valid_q, valid_d;
    logic [ISSUE_NUM*PAYLOAD_W-1:0] payload_q, payload_d;
    logic [ISSUE_NUM*REG_AW-1:0]    rs1_q, rs1_d;
    logic [ISSUE_NUM*REG_AW-1:0]    rs2_q, rs2_d;
    logic [ISSUE_NUM*REG_AW-1:0]    rd_q, rd_d;

    logic               split_found;
    logic [LANE_W-1:0]  split_lane;
    logic [SPLIT_W-1:0] split_cnt;

    assign in_ready = ~rst & ~stall_in & ~flush & (state_q == IDLE) & (rem_q == '0);

    // Lowest valid lane with a nonzero split count owns the replay.
    always_comb begin
        split_found = 1'b0;
        split_lane  = '0;
        split_cnt   = '0;
        for (int i = ISSUE_NUM - 1; i >= 0; i--) begin
            if (in_valid[i] && in_split[i*SPLIT_W +: SPLIT_W] != '0) begin
                split_found = 1'b1;
                split_lane  = LANE_W'(i);
                split_cnt   = in_split[i*SPLIT_W +: SPLIT_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        beat_d    = beat_q;
        lane_d    = lane_q;
        valid_d   = valid_q;
        payload_d = payload_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        if (flush) begin
            valid_d = '0;
            state_d = IDLE;
            rem_d   = '0;
            beat_d  = '0;
        end else if (!stall_in) begin
            if (rem_q != '0) begin
                valid_d         = '0;
                valid_d[lane_q] = 1'b1;
                beat_d          = beat_q + SPLIT_W'(1);
                rem_d           = rem_q - SPLIT_W'(1);
                // Last beat shows in IDLE so upstream is held for exactly K cycles.
                state_d         = (rem_q == SPLIT_W'(1)) ? IDLE : REPLAY;
            end else if (in_ready) begin
                valid_d   = in_valid;
                payload_d = in_payload;
                rs1_d     = in_rs1;
                rs2_d     = in_rs2;
                rd_d      = in_rd;
                beat_d    = '0;
                lane_d    = split_lane;
                rem_d     = split_found ? split_cnt : '0;
                state_d   = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            beat_q    <= '0;
            lane_q    <= '0;
            valid_q   <= '0;
            payload_q <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            beat_q    <= beat_d;
            lane_q    <= lane_d;
            valid_q   <= valid_d;
            payload_q <= payload_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_payload = payload_q;

    for (genvar i = 0; i < ISSUE_NUM; i++) begin : g_lane
        logic [SPLIT_W-1:0] lane_beat;
        logic [REG_AW-1:0]  adj;

        assign lane_beat = (lane_q == LANE_W'(i)) ? beat_q : '0;
        assign adj       = REG_AW'(lane_beat);

        assign out_beat[i*SPLIT_W +: SPLIT_W]          = lane_beat;
        assign out_rd[i*REG_AW +: REG_AW]              = rd_q[i*REG_AW +: REG_AW] + adj;
        assign reg_raddr[(2*i)*REG_AW +: REG_AW]       = rs1_q[i*REG_AW +: REG_AW] + adj;
        assign reg_raddr[(2*i+1)*REG_AW +: REG_AW]     = rs2_q[i*REG_AW +: REG_AW] + adj;

        operand_forward_mux #(
            .ISSUE_NUM (ISSUE_NUM),
            .DATA_W    (DATA_W),
            .REG_AW    (REG_AW),
            .FWD_DEPTH (FWD_DEPTH)
        ) u_fwd_op1 (
            .fwd_we    (fwd_we),
            .fwd_waddr (fwd_waddr),
            .fwd_wdata (fwd_wdata),
            .raddr     (reg_raddr[(2*i)*REG_AW +: REG_AW]),
            .rdata     (reg_rdata[(2*i)*DATA_W +: DATA_W]),
            .data      (out_op1[i*DATA_W +: DATA_W])
        );

        operand_forward_mux #(
            .ISSUE_NUM (ISSUE_NUM),
            .DATA_W    (DATA_W),
            .REG_AW    (REG_AW),
            .FWD_DEPTH (FWD_DEPTH)
        ) u_fwd_op2 (
            .fwd_we    (fwd_we),
            .fwd_waddr (fwd_waddr),
            .fwd_wdata (fwd_wdata),
            .raddr     (reg_raddr[(2*i+1)*REG_AW +: REG_AW]),
            .rdata     (reg_rdata[(2*i+1)*DATA_W +: DATA_W]),
            .data      (out_op2[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_issue_ro_split_stage.sv
// Directed bench for issue_ro_split_stage with a queue of expected register contents.
module tb_issue_ro_split_stage;

    logic          clk;
    logic          rst;
    logic          stall_in;
    logic          flush;
    logic [1:0]    in_valid;
    logic [127:0]  in_payload;
    logic [9:0]    in_rs1, in_rs2, in_rd;
    logic [3:0]    in_split;
    logic          in_ready;
    logic [19:0]   reg_raddr;
    logic [127:0]  reg_rdata;
    logic [7:0]    fwd_we;
    logic [39:0]   fwd_waddr;
    logic [255:0]  fwd_wdata;
    logic [1:0]    out_valid;
    logic [127:0]  out_payload;
    logic [9:0]    out_rd;
    logic [3:0]    out_beat;
    logic [63:0]   out_op1, out_op2;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  valid;
        logic [9:0]  rd;
        logic [3:0]  beat;
        logic [19:0] raddr;
    } exp_t;

    exp_t sb_q[$];

    issue_ro_split_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall_in    (stall_in),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_payload  (in_payload),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_rd       (in_rd),
        .in_split    (in_split),
        .in_ready    (in_ready),
        .reg_raddr   (reg_raddr),
        .reg_rdata   (reg_rdata),
        .fwd_we      (fwd_we),
        .fwd_waddr   (fwd_waddr),
        .fwd_wdata   (fwd_wdata),
        .out_valid   (out_valid),
        .out_payload (out_payload),
        .out_rd      (out_rd),
        .out_beat    (out_beat),
        .out_op1     (out_op1),
        .out_op2     (out_op2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] v, input logic [9:0] rd, input logic [3:0] b,
                            input logic [19:0] ra);
        exp_t e;
        e.valid = v;
        e.rd    = rd;
        e.beat  = b;
        e.raddr = ra;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        n_cmp++;
        assert (sb_q.size() != 0) else begin
            n_err++;
            $error("FAIL %s: observed empty scoreboard expected pending entry", tag);
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, ".valid"}, 64'(out_valid), 64'(e.valid));
            chk({tag, ".rd"},    64'(out_rd),    64'(e.rd));
            chk({tag, ".beat"},  64'(out_beat),  64'(e.beat));
            chk({tag, ".raddr"}, 64'(reg_raddr), 64'(e.raddr));
        end
    endtask

    task automatic set_lane(input int i, input logic v, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd, input logic [1:0] sp);
        in_valid[i]            = v;
        in_rs1[i*5 +: 5]       = rs1;
        in_rs2[i*5 +: 5]       = rs2;
        in_rd[i*5 +: 5]        = rd;
        in_split[i*2 +: 2]     = sp;
        in_payload[i*64 +: 64] = {32'hC0DE_0000, 27'd0, rd};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        stall_in   = 1'b0;
        flush      = 1'b0;
        in_valid   = '0;
        in_payload = '0;
        in_rs1     = '0;
        in_rs2     = '0;
        in_rd      = '0;
        in_split   = '0;
        fwd_we     = '0;
        fwd_waddr  = '0;
        fwd_wdata  = '0;
        for (int k = 0; k < 4; k++) reg_rdata[k*32 +: 32] = 32'h1000_0000 + 32'(k);

        // Reset state
        #1;
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.out_payload", out_payload[63:0], 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rel.in_ready", 64'(in_ready), 64'd1);

        // Normal group
        set_lane(0, 1'b1, 5'd3, 5'd4, 5'd5, 2'd0);
        set_lane(1, 1'b1, 5'd7, 5'd8, 5'd9, 2'd0);
        push_exp(2'b11, {5'd9, 5'd5}, 4'h0, {5'd8, 5'd7, 5'd4, 5'd3});
        tick();
        in_valid = '0;
        #1;
        sb_check("norm");
        chk("norm.in_ready", 64'(in_ready), 64'd1);
        chk("norm.payload", out_payload[63:0], {32'hC0DE_0000, 32'd5});
        chk("norm.op1_rf", 64'(out_op1[31:0]), 64'h1000_0000);

        // Split replay: lane 1 split=1
        set_lane(0, 1'b1, 5'd1, 5'd2, 5'd3, 2'd0);
        set_lane(1, 1'b1, 5'd5, 5'd6, 5'd4, 2'd1);
        push_exp(2'b11, {5'd4, 5'd3}, 4'h0, {5'd6, 5'd5, 5'd2, 5'd1});
        push_exp(2'b10, {5'd5, 5'd3}, 4'h4, {5'd7, 5'd6, 5'd2, 5'd1});
        tick();
        in_valid = '0;
        #1;
        sb_check("split.b0");
        chk("split.b0.in_ready", 64'(in_ready), 64'd0);
        tick();
        sb_check("split.b1");
        chk("split.b1.in_ready", 64'(in_ready), 64'd1);

        // Wrap and two split lanes: only lane 0 replays
        set_lane(0, 1'b1, 5'd10, 5'd11, 5'd30, 2'd2);
        set_lane(1, 1'b1, 5'd12, 5'd13, 5'd20, 2'd1);
        push_exp(2'b11, {5'd20, 5'd30}, 4'h0, {5'd13, 5'd12, 5'd11, 5'd10});
        push_exp(2'b01, {5'd20, 5'd31}, 4'h1, {5'd13, 5'd12, 5'd12, 5'd11});
        push_exp(2'b01, {5'd20, 5'd0},  4'h2, {5'd13, 5'd12, 5'd13, 5'd12});
        tick();
        in_valid = '0;
        #1;
        sb_check("wrap.b0");
        chk("wrap.b0.in_ready", 64'(in_ready), 64'd0);
        tick();
        sb_check("wrap.b1");
        chk("wrap.b1.in_ready", 64'(in_ready), 64'd0);
        tick();
        sb_check("wrap.b2");
        chk("wrap.b2.in_ready", 64'(in_ready), 64'd1);

        // Forwarding priority and zero register
        set_lane(0, 1'b1, 5'd9, 5'd0, 5'd1, 2'd0);
        set_lane(1, 1'b1, 5'd0, 5'd9, 5'd2, 2'd0);
        push_exp(2'b11, {5'd2, 5'd1}, 4'h0, {5'd9, 5'd0, 5'd0, 5'd9});
        tick();
        in_valid = '0;
        fwd_we = 8'b0001_0111;
        fwd_waddr[0*5 +: 5]   = 5'd9;  fwd_wdata[0*32 +: 32] = 32'hAAAA_0001;
        fwd_waddr[1*5 +: 5]   = 5'd9;  fwd_wdata[1*32 +: 32] = 32'hBBBB_0002;
        fwd_waddr[2*5 +: 5]   = 5'd0;  fwd_wdata[2*32 +: 32] = 32'hDDDD_0004;
        fwd_waddr[4*5 +: 5]   = 5'd9;  fwd_wdata[4*32 +: 32] = 32'hCCCC_0003;
        #1;
        sb_check("fwd");
        chk("fwd.l0op1_B", 64'(out_op1[31:0]), 64'hBBBB_0002);
        chk("fwd.l0op2_zero", 64'(out_op2[31:0]), 64'd0);
        chk("fwd.l1op1_zero", 64'(out_op1[63:32]), 64'd0);
        chk("fwd.l1op2_B", 64'(out_op2[63:32]), 64'hBBBB_0002);
        fwd_we = 8'b0001_0100;
        #1;
        chk("fwd.l0op1_C", 64'(out_op1[31:0]), 64'hCCCC_0003);
        fwd_we = '0;
        #1;
        chk("fwd.l0op1_rf", 64'(out_op1[31:0]), 64'h1000_0000);

        // Stall during beat 1, then flush together with stall
        set_lane(0, 1'b1, 5'd2, 5'd3, 5'd1, 2'd2);
        set_lane(1, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0);
        push_exp(2'b01, {5'd0, 5'd1}, 4'h0, {5'd0, 5'd0, 5'd3, 5'd2});
        push_exp(2'b01, {5'd0, 5'd2}, 4'h1, {5'd0, 5'd0, 5'd4, 5'd3});
        tick();
        in_valid = '0;
        #1;
        sb_check("stl.b0");
        tick();
        sb_check("stl.b1");
        stall_in = 1'b1;
        #1;
        chk("stl.in_ready", 64'(in_ready), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stl.hold_beat", 64'(out_beat), 64'h1);
            chk("stl.hold_rd", 64'(out_rd), 64'({5'd0, 5'd2}));
            chk("stl.hold_valid", 64'(out_valid), 64'b01);
        end
        flush = 1'b1;
        tick();
        chk("flush.out_valid", 64'(out_valid), 64'd0);
        chk("flush.beat", 64'(out_beat), 64'd0);
        flush    = 1'b0;
        stall_in = 1'b0;
        #1;
        chk("flush.in_ready", 64'(in_ready), 64'd1);

        // Asynchronous reset in the middle of a replay
        set_lane(0, 1'b1, 5'd6, 5'd7, 5'd5, 2'd3);
        push_exp(2'b01, {5'd0, 5'd5}, 4'h0, {5'd0, 5'd0, 5'd7, 5'd6});
        push_exp(2'b01, {5'd0, 5'd6}, 4'h1, {5'd0, 5'd0, 5'd8, 5'd7});
        push_exp(2'b01, {5'd0, 5'd7}, 4'h2, {5'd0, 5'd0, 5'd9, 5'd8});
        tick();
        in_valid = '0;
        #1;
        sb_check("arst.b0");
        tick();
        sb_check("arst.b1");
        tick();
        sb_check("arst.b2");
        #2 rst = 1'b1;
        #1;
        chk("arst.out_valid", 64'(out_valid), 64'd0);
        chk("arst.in_ready_hi", 64'(in_ready), 64'd0);
        #1 rst = 1'b0;
        #1;
        chk("arst.in_ready", 64'(in_ready), 64'd1);
        chk("arst.beat", 64'(out_beat), 64'd0);
        tick();
        chk("arst.idle_valid", 64'(out_valid), 64'd0);
        chk("arst.idle_ready", 64'(in_ready), 64'd1);

        chk("sb.drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/issue_ro_split_stage.md
Name: issue_ro_split_stage

Overview:
- Parametrised IS->RO pipeline stage for an N-wide in-order issue core.
- Registers the issued group and generates register-file read addresses.
- Forwards operands from a configurable number of producer stages.
- Generalises the fixed two-beat FPU split (LDC1/SDC1 A/B) to an arbitrary micro-op count. During a split replay it stalls upstream and re-emits the split lane with incremented register indices.

Parameters:
- ISSUE_NUM, 2, issue lanes per group
- DATA_W, 32, operand/result width
- REG_AW, 5, register address width
- FWD_DEPTH, 4, producer stages forwarded from; stage 0 is youngest (EX), then D$..., MM, WB
- MAX_SPLIT, 3, maximum extra beats per split op
- SPLIT_W, $clog2(MAX_SPLIT+1), split count/beat width
- PAYLOAD_W, 64, opaque per-lane payload (fetch/decoded bits), passed through unchanged

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- stall_in  in  1  downstream (RO) stall; hold register
- flush  in  1  clear register, abort replay
- in_valid  in  ISSUE_NUM  lane valid from issue logic
- in_payload  in  ISSUE_NUM*PAYLOAD_W  per-lane payload
- in_rs1, in_rs2, in_rd  in  ISSUE_NUM*REG_AW each  source/destination addresses
- in_split  in  ISSUE_NUM*SPLIT_W  extra beats required (0 = normal op)
- in_ready  out  1  group accepted this cycle; replaces stall_from_id (stall = ~in_ready)
- reg_raddr  out  2*ISSUE_NUM*REG_AW  RF read addresses; lane i at 2i (rs1) and 2i+1 (rs2)
- reg_rdata  in  2*ISSUE_NUM*DATA_W  RF read data
- fwd_we  in  FWD_DEPTH*ISSUE_NUM  producer write enables
- fwd_waddr  in  FWD_DEPTH*ISSUE_NUM*REG_AW  producer destinations
- fwd_wdata  in  FWD_DEPTH*ISSUE_NUM*DATA_W  producer results
- out_valid  out  ISSUE_NUM  registered lane valid
- out_payload  out  ISSUE_NUM*PAYLOAD_W  registered payload
- out_rd  out  ISSUE_NUM*REG_AW  destination plus beat
- out_beat  out  ISSUE_NUM*SPLIT_W  beat index of the lane (0 = first)
- out_op1, out_op2  out  ISSUE_NUM*DATA_W each  forwarded operands

Behaviour:
- Reset (async, rst=1): all out_valid=0; payload/addresses/beat = 0; state=IDLE; beat counter=0. in_ready=0 while rst is high. The first acceptance happens on the first rising edge after rst falls.
- States:
  - IDLE: register holds a normal or first-beat group.
  - REPLAY: register holds beat b>=1 of split lane L.
- in_ready = ~stall_in & ~flush & (state==IDLE) & ~(registered group has a pending split).
- Edge priority: flush > stall_in > replay advance > load.
  - flush=1: out_valid<=0; state<=IDLE (aborts any replay, including mid-stall).
  - stall_in=1 (no flush): all state held.
- Load (in_ready=1):
  - Register all lanes with beat=0.
  - Among valid lanes with in_split>0, L = lowest index; higher lanes' split counts are treated as 0.
  - If an L exists, record L and remaining=in_split[L]. The next unstalled edge enters REPLAY.
- Replay step (each unstalled, unflushed edge while remaining>0):
  - Lane L only: out_valid=one-hot(L), payload held, beat+=1.
  - rd, rs1, rs2 all = original + beat, modulo 2^REG_AW (wraps; 31+1 -> 0).
  - remaining decrements. When it reaches 0, the following edge returns to IDLE and in_ready re-asserts combinationally in that cycle.
  - A group with split K therefore occupies K+1 register cycles. Upstream sees in_ready=0 for exactly K unstalled cycles.
- reg_raddr is driven combinationally from the registered (beat-adjusted) rs1/rs2.
- Forwarding (combinational, per operand):
  - Address 0 yields 0; no forwarding on address 0.
  - Otherwise scan stage 0..FWD_DEPTH-1. Within a stage, the highest lane index wins (younger in program order). The first hit with fwd_we=1 supplies data.
  - No hit: reg_rdata.
  - Lanes with out_valid=0 still compute operands; the value is don't-care.
- No intra-group forwarding; lane hazards are the issue logic's responsibility.
- Latency: one cycle IS->RO; operands are valid in the same cycle as out_valid.

Decomposition:
- Shared package (cpu_defs): reg_addr_t, uint32_t, the split-count typedef, and the state enum {IDLE, REPLAY}.
- Sub-module operand_forward_mux (one operand: FWD_DEPTH x ISSUE_NUM priority select with zero-register rule), instantiated 2*ISSUE_NUM times.

Test Plan:
- Reset mid-replay: load split=3, assert rst during beat 2 -> out_valid=0 immediately (async), in_ready=1 after release, state IDLE.
- Normal group: lanes 0,1 valid, split 0, rs1=3 -> next cycle out_valid=2'b11, reg_raddr[0]=3, in_ready stays 1.
- Split replay: lane 1 split=1, rd=4, rs2=6 -> beat0 both lanes; beat1 only lane 1, out_rd=5, reg_raddr[3]=7, out_beat=1; in_ready=0 for exactly 1 cycle.
- Wrap and multiple splits: lane 0 split=2 rd=30, lane 1 split=1 -> lane 0 replays rd=31 then 0; lane 1 emitted once.
- Forward priority: rs1=9; stage0 lane0 we=1 data=A, stage0 lane1 we=1 data=B, stage2 data=C -> op1=B. Same with rs1=0 -> op1=0.
- Stall/flush interaction: stall_in=1 for 3 cycles during beat 1 -> outputs frozen, beat unchanged. Flush+stall on the same edge -> out_valid=0, IDLE.
